// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes and the shared synchronous memory port used by mem_port_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0, we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0, done0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1, we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1, done1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, done0, rdata0,
    output gnt1, done1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, done0, rdata0,
    input  gnt1, done1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified instruction/data memory port: round-robin on ties,
// one transaction in flight, fixed-latency memory handshake, all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clock,
  input  logic             resetn,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic arb_req;
  logic arb_win;

  // On a tie the port that did not win last time goes first.
  assign arb_req = bus.req0 | bus.req1;
  assign arb_win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (arb_req) begin
          state_d  = ISSUE;
          id_d     = arb_win;
          last_d   = arb_win;
          we_d     = arb_win ? bus.we1    : bus.we0;
          addr_d   = arb_win ? bus.addr1  : bus.addr0;
          wdata_d  = arb_win ? bus.wdata1 : bus.wdata0;
          mem_en_d = 1'b1;
          mem_we_d = arb_win ? bus.we1    : bus.we0;
          gnt0_d   = ~arb_win;
          gnt1_d   = arb_win;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Memory data is valid at the edge where the count reaches one.
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          done0_d = ~id_q;
          done1_d = id_q;
          if (!we_q) begin
            if (id_q) rdata1_d = bus.mem_rdata;
            else      rdata0_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-1 instance with a scoreboard on completions,
// and a latency-3 instance for exact done timing and mid-flight input changes.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_a (
    .clock (clock),
    .resetn(resetn),
    .bus   (ifa)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_b (
    .clock (clock),
    .resetn(resetn),
    .bus   (ifb)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory models: data is driven only in the cycle the arbiter should sample it.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] ref_a [0:255];
  bit          init_a, init_b;
  int          pa_cnt, pb_cnt;
  bit          pa_vld, pb_vld;
  logic [31:0] pa_data, pb_data;

  always @(posedge clock) begin
    if (!init_a) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'h1000_0000 + 32'(i);
      mem_a[4] <= 32'hDEAD_BEEF;
      init_a   <= 1'b1;
    end else if (ifa.mem_en) begin
      if (ifa.mem_we) mem_a[ifa.mem_addr[9:2]] <= ifa.mem_wdata;
      pa_data <= mem_a[ifa.mem_addr[9:2]];
      pa_vld  <= !ifa.mem_we;
      pa_cnt  <= 1;
    end else if (pa_cnt != 0) begin
      pa_cnt <= pa_cnt - 1;
    end
  end
  assign ifa.mem_rdata = (pa_vld && pa_cnt == 1) ? pa_data : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    if (!init_b) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 32'h2000_0000 + 32'(i);
      mem_b[12] <= 32'hCAFE_F00D;
      mem_b[13] <= 32'h0BAD_CAFE;
      init_b    <= 1'b1;
    end else if (ifb.mem_en) begin
      if (ifb.mem_we) mem_b[ifb.mem_addr[9:2]] <= ifb.mem_wdata;
      pb_data <= mem_b[ifb.mem_addr[9:2]];
      pb_vld  <= !ifb.mem_we;
      pb_cnt  <= 3;
    end else if (pb_cnt != 0) begin
      pb_cnt <= pb_cnt - 1;
    end
  end
  assign ifb.mem_rdata = (pb_vld && pb_cnt == 1) ? pb_data : 32'hBAD0_BAD0;

  // Scoreboard for instance A: one entry per accepted request, popped on done.
  typedef struct {
    bit          port;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t        sb [$];
  logic [31:0] last_rd0 = '0;
  logic [31:0] last_rd1 = '0;
  int          we_cycles = 0;

  always @(negedge clock) begin : monitor_a
    exp_t e;
    if (ifa.mem_we) begin
      we_cycles++;
      check_val("we_needs_en", ifa.mem_en, 1);
    end
    if (ifa.gnt0 || ifa.gnt1) check_val("gnt_excl", ifa.gnt0 & ifa.gnt1, 0);
    if (ifa.done0 || ifa.done1) begin
      check_val("done_excl", ifa.done0 & ifa.done1, 0);
      if (sb.size() == 0) begin
        check_val("done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("done_port", ifa.done1, e.port);
        if (e.port) begin
          if (e.rd) last_rd1 = e.data;
        end else begin
          if (e.rd) last_rd0 = e.data;
        end
        check_val("rdata0", ifa.rdata0, last_rd0);
        check_val("rdata1", ifa.rdata1, last_rd1);
      end
    end
  end

  task automatic issue(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.port = port;
    e.rd   = !we;
    e.data = we ? 32'h0 : ref_a[addr[9:2]];
    if (we) ref_a[addr[9:2]] = wdata;
    sb.push_back(e);
    if (port) begin
      ifa.req1 = 1'b1; ifa.we1 = we; ifa.addr1 = addr; ifa.wdata1 = wdata;
    end else begin
      ifa.req0 = 1'b1; ifa.we0 = we; ifa.addr0 = addr; ifa.wdata0 = wdata;
    end
    for (int t = 0; t < 20; t++) begin
      @(posedge clock); #1;
      if (port ? ifa.gnt1 : ifa.gnt0) begin
        check_val("issue_we", ifa.mem_we, we);
        check_val("issue_addr", ifa.mem_addr, addr);
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
        return;
      end
    end
    check_val("gnt_timeout", 0, 1);
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40; t++) begin
      @(posedge clock); #1;
      if (!ifa.busy && sb.size() == 0) return;
    end
    check_val("idle_timeout", 0, 1);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_gnt"},   {ifa.gnt0, ifa.gnt1}, 0);
    check_val({tag, "_done"},  {ifa.done0, ifa.done1}, 0);
    check_val({tag, "_mem"},   {ifa.mem_en, ifa.mem_we}, 0);
    check_val({tag, "_addr"},  ifa.mem_addr, 0);
    check_val({tag, "_wdata"}, ifa.mem_wdata, 0);
    check_val({tag, "_rd0"},   ifa.rdata0, 0);
    check_val({tag, "_rd1"},   ifa.rdata1, 0);
    check_val({tag, "_busy"},  ifa.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gcount, n0, n1, we_before;
    int gorder [4];
    int gcyc [4];

    for (int i = 0; i < 256; i++) ref_a[i] = 32'h1000_0000 + 32'(i);
    ref_a[4] = 32'hDEAD_BEEF;
    resetn = 1'b0;
    {ifa.req0, ifa.we0, ifa.req1, ifa.we1} = '0;
    {ifa.addr0, ifa.wdata0, ifa.addr1, ifa.wdata1} = '0;
    {ifb.req0, ifb.we0, ifb.req1, ifb.we1} = '0;
    {ifb.addr0, ifb.wdata0, ifb.addr1, ifb.wdata1} = '0;

    repeat (3) @(posedge clock);
    #1;
    check_cleared("rst");
    @(negedge clock);
    resetn = 1'b1;

    // Core read of 0x10, exact cycle timing at latency 1.
    sb.push_back('{port: 1'b0, rd: 1'b1, data: 32'hDEAD_BEEF});
    ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 32'h10;
    @(posedge clock); #1;
    check_val("t1_gnt0", ifa.gnt0, 1);
    check_val("t1_mem_en", ifa.mem_en, 1);
    check_val("t1_mem_addr", ifa.mem_addr, 32'h10);
    check_val("t1_busy", ifa.busy, 1);
    ifa.req0 = 1'b0;
    @(posedge clock); #1;
    check_val("t1_gnt_pulse", {ifa.gnt0, ifa.mem_en, ifa.done0}, 0);
    @(posedge clock); #1;
    check_val("t1_done0", ifa.done0, 1);
    check_val("t1_rdata0", ifa.rdata0, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    check_val("t1_idle", {ifa.busy, ifa.done0}, 0);

    // Loader write then core read-back.
    @(negedge clock);
    we_before = we_cycles;
    issue(1'b1, 1'b1, 32'h0, 32'h0000_0013);
    wait_idle();
    check_val("t2_we_cycles", we_cycles - we_before, 1);
    @(negedge clock);
    issue(1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();
    check_val("t2_readback", ifa.rdata0, 32'h0000_0013);

    // Reset asserted while a core read sits in WAIT.
    @(negedge clock);
    ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 32'h10;
    @(posedge clock); #1;
    check_val("t5_gnt0", ifa.gnt0, 1);
    ifa.req0 = 1'b0;
    @(posedge clock); #1;
    check_val("t5_in_wait", {ifa.busy, ifa.mem_en}, 2'b10);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock); #1;
    check_cleared("t5_rst");
    @(negedge clock);
    resetn   = 1'b1;
    last_rd0 = '0;
    last_rd1 = '0;

    // Both ports requesting continuously: expect 0,1,0,1 every 3 cycles.
    sb.push_back('{port: 1'b0, rd: 1'b1, data: ref_a[8]});
    sb.push_back('{port: 1'b1, rd: 1'b1, data: ref_a[16]});
    sb.push_back('{port: 1'b0, rd: 1'b1, data: ref_a[9]});
    sb.push_back('{port: 1'b1, rd: 1'b1, data: ref_a[17]});
    gcount = 0; n0 = 0; n1 = 0;
    ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.addr0 = 32'h20;
    ifa.req1 = 1'b1; ifa.we1 = 1'b0; ifa.addr1 = 32'h40;
    for (int t = 0; t < 40 && gcount < 4; t++) begin
      @(posedge clock); #1;
      if (!ifa.req0 && n0 < 2) begin ifa.req0 = 1'b1; ifa.addr0 = 32'h20 + 32'(4 * n0); end
      if (!ifa.req1 && n1 < 2) begin ifa.req1 = 1'b1; ifa.addr1 = 32'h40 + 32'(4 * n1); end
      if (ifa.gnt0) begin gorder[gcount] = 0; gcyc[gcount] = cyc; gcount++; n0++; ifa.req0 = 1'b0; end
      if (ifa.gnt1) begin gorder[gcount] = 1; gcyc[gcount] = cyc; gcount++; n1++; ifa.req1 = 1'b0; end
    end
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
    check_val("t3_grants", gcount, 4);
    for (int i = 0; i < 4; i++) check_val("t3_order", gorder[i], i % 2);
    for (int i = 1; i < 4; i++) check_val("t3_period", gcyc[i] - gcyc[i-1], 3);
    wait_idle();

    // Latency 3 instance: done timing and inputs changed mid-flight.
    @(negedge clock);
    ifb.req0 = 1'b1; ifb.we0 = 1'b0; ifb.addr0 = 32'h30; ifb.wdata0 = 32'h1234_5678;
    @(posedge clock); #1;
    check_val("b_gnt0", ifb.gnt0, 1);
    check_val("b_mem_en", ifb.mem_en, 1);
    ifb.req0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin ifb.addr0 = 32'h34; ifb.wdata0 = 32'h55; end
      check_val("b_done_early", ifb.done0, 0);
      check_val("b_mem_addr", ifb.mem_addr, 32'h30);
      check_val("b_mem_wdata", ifb.mem_wdata, 32'h1234_5678);
    end
    @(posedge clock); #1;
    check_val("b_done0", ifb.done0, 1);
    check_val("b_rdata0", ifb.rdata0, 32'hCAFE_F00D);
    @(posedge clock); #1;
    check_val("b_idle", {ifb.done0, ifb.busy}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
